evf_rx_aligner: RTL and testbench

Receive-side link aligner and event decoder for the event fanout (EVF) MGT link. It sits between the GTX receive fabric interface and the event logic, in the recovered `rxClk` domain. It finds K28.5 comma alignment by pulsing the transceiver's manual RXSLIDE, then declares `rxIsAligned`. While aligned it decodes each 16-bit word into an event code (low byte) and a distributed-bus byte (high byte), and drops alignment on excessive code errors or comma loss.

---
 rtl/evf_pkg.sv | 15 +
 rtl/evf_rx_err_monitor.sv | 54 +++++
 rtl/evf_rx_aligner.sv | 182 ++++++++++++++++++
 tb/tb_evf_rx_aligner.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evf_pkg.sv
// evf_pkg: shared constants and state type for the EVF receive path.
// Holds the K28.5 comma byte, the null event code and the aligner states.
package evf_pkg;

  localparam logic [7:0] K28_5   = 8'hBC;
  localparam logic [7:0] EV_NULL = 8'h00;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIDE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } evf_rx_state_t;

endpackage

// File: rtl/evf_rx_err_monitor.sv
// evf_rx_err_monitor: windowed code-error rate limit and error counter.
// In: clk, rst_n, i_locked, i_err. Out: o_limit_hit, o_code_err_count.
module evf_rx_err_monitor
  import evf_pkg::*;
#(
  parameter int ERR_WINDOW = 256,
  parameter int ERR_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_locked,
  input  logic        i_err,
  output logic        o_limit_hit,
  output logic [15:0] o_code_err_count
);

  localparam int WW =
    (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int CW = $clog2(ERR_LIMIT + 1);
  localparam logic [WW-1:0] WIN_LAST =
    WW'(ERR_WINDOW - 1);
  localparam logic [CW-1:0] LIMIT = CW'(ERR_LIMIT);

  logic [WW-1:0] r_win;
  logic [CW-1:0] r_errs;
  logic [15:0]   r_cnt;
  logic          w_wrap;
  logic          w_count;
  logic [CW-1:0] w_errs;

  assign w_wrap  = (r_win == WIN_LAST);
  assign w_count = i_locked & i_err;

  // The wrap cycle already belongs to the new window.
  assign w_errs =
    (w_wrap ? '0 : r_errs) + CW'(w_count);

  assign o_limit_hit      = w_count & (w_errs >= LIMIT);
  assign o_code_err_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win  <= '0;
      r_errs <= '0;
      r_cnt  <= '0;
    end else begin
      r_win  <= w_wrap ? '0 : r_win + WW'(1);
      r_errs <= i_locked ? w_errs : '0;
      if (w_count && r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/evf_rx_aligner.sv
// evf_rx_aligner: GTX RX comma aligner (RXSLIDE) and event/dbus decoder.
// In: rxClk, rxRst_n, rxData, rxCharIsK, rxNotInTable, rxDispErr,
//     slideRequest. Out: rxSlide, rxIsAligned, evCode, evValid,
//     dbusData, codeErrCount.
module evf_rx_aligner
  import evf_pkg::*;
#(
  parameter logic [7:0] COMMA         = K28_5,
  parameter int         ALIGN_COUNT   = 8,
  parameter int         SLIDE_WAIT    = 32,
  parameter int         COMMA_TIMEOUT = 4096,
  parameter int         ERR_WINDOW    = 256,
  parameter int         ERR_LIMIT     = 4
) (
  input  logic        rxClk,
  input  logic        rxRst_n,
  input  logic [15:0] rxData,
  input  logic [1:0]  rxCharIsK,
  input  logic [1:0]  rxNotInTable,
  input  logic [1:0]  rxDispErr,
  input  logic        slideRequest,
  output logic        rxSlide,
  output logic        rxIsAligned,
  output logic [7:0]  evCode,
  output logic        evValid,
  output logic [7:0]  dbusData,
  output logic [15:0] codeErrCount
);

  localparam int GW = $clog2(ALIGN_COUNT + 1);
  localparam int WW =
    (SLIDE_WAIT > 1) ? $clog2(SLIDE_WAIT) : 1;
  localparam int TW =
    (COMMA_TIMEOUT > 1) ? $clog2(COMMA_TIMEOUT) : 1;
  localparam logic [GW-1:0] GOOD_LAST =
    GW'(ALIGN_COUNT - 1);
  localparam logic [WW-1:0] WAIT_LAST =
    WW'(SLIDE_WAIT - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(COMMA_TIMEOUT - 1);

  evf_rx_state_t r_state;
  evf_rx_state_t w_next;

  logic [GW-1:0] r_good_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_req_d;

  logic w_err;
  logic w_good;
  logic w_high;
  logic w_req_rise;
  logic w_to;
  logic w_err_hit;
  logic w_locked;

  logic w_ev;
  logic w_db;

  logic        r_slide;
  logic        r_aligned;
  logic        r_ev_valid;
  logic [7:0]  r_ev_code;
  logic [7:0]  r_dbus;
  logic [15:0] w_code_err_count;

  assign w_err = (|rxNotInTable) | (|rxDispErr);

  assign w_good = ~w_err & rxCharIsK[0] &
                  (rxData[7:0] == COMMA);

  assign w_high = ~w_err & rxCharIsK[1] &
                  (rxData[15:8] == COMMA);

  assign w_req_rise = slideRequest & ~r_req_d;
  assign w_locked   = (r_state == ST_LOCKED);

  // Counter saturates at TO_LAST, so the next
  // non-comma cycle is the COMMA_TIMEOUT-th one.
  assign w_to = ~w_good & (r_to_cnt == TO_LAST);

  evf_rx_err_monitor #(
    .ERR_WINDOW (ERR_WINDOW),
    .ERR_LIMIT  (ERR_LIMIT)
  ) u_err_mon (
    .clk              (rxClk),
    .rst_n            (rxRst_n),
    .i_locked         (w_locked),
    .i_err            (w_err),
    .o_limit_hit      (w_err_hit),
    .o_code_err_count (w_code_err_count)
  );

  always_ff @(posedge rxClk or negedge rxRst_n) begin
    if (!rxRst_n) begin
      r_state    <= ST_HUNT;
      r_req_d    <= 1'b0;
      r_good_cnt <= '0;
      r_wait_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_req_d <= slideRequest;
      if (w_next != r_state) begin
        r_good_cnt <= '0;
        r_wait_cnt <= '0;
        r_to_cnt   <= '0;
      end else begin
        if (r_state == ST_HUNT && w_good)
          r_good_cnt <= r_good_cnt + GW'(1);
        if (r_state == ST_WAIT)
          r_wait_cnt <= r_wait_cnt + WW'(1);
        if (w_good)
          r_to_cnt <= '0;
        else if (r_to_cnt != TO_LAST)
          r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_HUNT: begin
        if (w_req_rise | w_err | w_high | w_to)
          w_next = ST_SLIDE;
        else if (w_good && r_good_cnt == GOOD_LAST)
          w_next = ST_LOCKED;
      end
      ST_SLIDE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (r_wait_cnt == WAIT_LAST)
          w_next = ST_HUNT;
      end
      ST_LOCKED: begin
        if (w_req_rise)
          w_next = ST_SLIDE;
        else if (w_err_hit | w_high | w_to)
          w_next = ST_HUNT;
      end
      default: w_next = ST_HUNT;
    endcase
  end

  // Decode only words that keep the link locked,
  // so no strobe accompanies an unlock.
  always_comb begin
    w_ev = 1'b0;
    w_db = 1'b0;
    if (w_locked && w_next == ST_LOCKED && !w_err) begin
      w_ev = ~rxCharIsK[0] & (rxData[7:0] != EV_NULL);
      w_db = ~rxCharIsK[1];
    end
  end

  always_ff @(posedge rxClk or negedge rxRst_n) begin
    if (!rxRst_n) begin
      r_slide    <= 1'b0;
      r_aligned  <= 1'b0;
      r_ev_valid <= 1'b0;
      r_ev_code  <= '0;
      r_dbus     <= '0;
    end else begin
      r_slide    <= (w_next == ST_SLIDE);
      r_aligned  <= (w_next == ST_LOCKED);
      r_ev_valid <= w_ev;
      if (w_ev)
        r_ev_code <= rxData[7:0];
      if (w_db)
        r_dbus <= rxData[15:8];
    end
  end

  assign rxSlide      = r_slide;
  assign rxIsAligned  = r_aligned;
  assign evCode       = r_ev_code;
  assign evValid      = r_ev_valid;
  assign dbusData     = r_dbus;
  assign codeErrCount = w_code_err_count;

endmodule

// File: tb/tb_evf_rx_aligner.sv
// tb_evf_rx_aligner: random and directed stimulus for evf_rx_aligner,
// checked every cycle against a behavioural link model.
module tb_evf_rx_aligner;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int ALIGN_COUNT   = 8;
  localparam int SLIDE_WAIT    = 32;
  localparam int COMMA_TIMEOUT = 4096;
  localparam int ERR_WINDOW    = 256;
  localparam int ERR_LIMIT     = 4;

  localparam int M_HUNT   = 0;
  localparam int M_SLIDE  = 1;
  localparam int M_WAIT   = 2;
  localparam int M_LOCKED = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rxData = '0;
  logic [1:0]  rxCharIsK = '0;
  logic [1:0]  rxNotInTable = '0;
  logic [1:0]  rxDispErr = '0;
  logic        slideRequest = 1'b0;
  logic        rxSlide;
  logic        rxIsAligned;
  logic [7:0]  evCode;
  logic        evValid;
  logic [7:0]  dbusData;
  logic [15:0] codeErrCount;

  int checks = 0;
  int failures = 0;

  evf_rx_aligner #(
    .COMMA         (COMMA),
    .ALIGN_COUNT   (ALIGN_COUNT),
    .SLIDE_WAIT    (SLIDE_WAIT),
    .COMMA_TIMEOUT (COMMA_TIMEOUT),
    .ERR_WINDOW    (ERR_WINDOW),
    .ERR_LIMIT     (ERR_LIMIT)
  ) dut (
    .rxClk        (clk),
    .rxRst_n      (rst_n),
    .rxData       (rxData),
    .rxCharIsK    (rxCharIsK),
    .rxNotInTable (rxNotInTable),
    .rxDispErr    (rxDispErr),
    .slideRequest (slideRequest),
    .rxSlide      (rxSlide),
    .rxIsAligned  (rxIsAligned),
    .evCode       (evCode),
    .evValid      (evValid),
    .dbusData     (dbusData),
    .codeErrCount (codeErrCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 name, act, exp, $time);
    end
  endtask

  // Behavioural model: link state, comma bookkeeping,
  // error windows by absolute cycle number.
  int   m_state = M_HUNT;
  int   m_good = 0;
  int   m_wait = 0;
  int   m_since = 0;
  int   m_cyc = 0;
  int   m_wid = -1;
  int   m_wcnt = 0;
  int   m_cerr = 0;
  bit   m_req_prev = 0;
  bit   e_slide = 0;
  bit   e_aligned = 0;
  bit   e_evv = 0;
  logic [7:0] e_code = '0;
  logic [7:0] e_dbus = '0;

  task automatic model_reset();
    m_state = M_HUNT;
    m_good = 0;
    m_wait = 0;
    m_since = 0;
    m_cyc = 0;
    m_wid = -1;
    m_wcnt = 0;
    m_cerr = 0;
    m_req_prev = 0;
    e_slide = 0;
    e_aligned = 0;
    e_evv = 0;
    e_code = '0;
    e_dbus = '0;
  endtask

  task automatic model_step();
    bit err, good, high, rise, tmo, hit;
    int nxt, id;
    err  = (rxNotInTable != 0) || (rxDispErr != 0);
    good = !err && rxCharIsK[0] && rxData[7:0] == COMMA;
    high = !err && rxCharIsK[1] && rxData[15:8] == COMMA;
    rise = slideRequest && !m_req_prev;
    m_req_prev = slideRequest;
    tmo = !good && (m_since + 1 >= COMMA_TIMEOUT);
    nxt = m_state;
    hit = 0;
    case (m_state)
      M_HUNT: begin
        if (rise || err || high || tmo) nxt = M_SLIDE;
        else if (good && m_good + 1 == ALIGN_COUNT)
          nxt = M_LOCKED;
      end
      M_SLIDE: nxt = M_WAIT;
      M_WAIT: if (m_wait + 1 == SLIDE_WAIT) nxt = M_HUNT;
      default: begin
        if (err) begin
          id = (m_cyc + 1) / ERR_WINDOW;
          if (id != m_wid) begin
            m_wid = id;
            m_wcnt = 0;
          end
          m_wcnt++;
          if (m_cerr < 65535) m_cerr++;
          hit = (m_wcnt >= ERR_LIMIT);
        end
        if (rise) nxt = M_SLIDE;
        else if (hit || high || tmo) nxt = M_HUNT;
      end
    endcase
    e_evv = 0;
    if (m_state == M_LOCKED && nxt == M_LOCKED && !err) begin
      if (!rxCharIsK[0] && rxData[7:0] != 8'h00) begin
        e_evv = 1;
        e_code = rxData[7:0];
      end
      if (!rxCharIsK[1]) e_dbus = rxData[15:8];
    end
    if (nxt != m_state) begin
      m_good = 0;
      m_wait = 0;
      m_since = 0;
      if (nxt == M_LOCKED) begin
        m_wid = -1;
        m_wcnt = 0;
      end
    end else begin
      if (m_state == M_HUNT && good) m_good++;
      if (m_state == M_WAIT) m_wait++;
      m_since = good ? 0 : m_since + 1;
    end
    e_slide = (nxt == M_SLIDE);
    e_aligned = (nxt == M_LOCKED);
    m_state = nxt;
    m_cyc++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rxSlide", rxSlide, e_slide);
      chk("rxIsAligned", rxIsAligned, e_aligned);
      chk("evValid", evValid, e_evv);
      chk("evCode", evCode, e_code);
      chk("dbusData", dbusData, e_dbus);
      chk("codeErrCount", codeErrCount, m_cerr);
    end
  end

  task automatic send(input logic [15:0] d,
                      input logic [1:0] k,
                      input logic [1:0] nit,
                      input logic [1:0] de);
    rxData = d;
    rxCharIsK = k;
    rxNotInTable = nit;
    rxDispErr = de;
    @(negedge clk);
  endtask

  task automatic send_comma();
    send({8'($urandom()), COMMA}, 2'b01, 2'b00, 2'b00);
  endtask

  task automatic send_data();
    send({8'($urandom()), 8'($urandom())},
         2'b00, 2'b00, 2'b00);
  endtask

  task automatic send_err();
    send({8'($urandom()), 8'($urandom())},
         2'b00, 2'b01, 2'b10);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    rxData = '0;
    rxCharIsK = '0;
    rxNotInTable = '0;
    rxDispErr = '0;
    slideRequest = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_lock(input string name);
    for (int i = 0; i <= 28; i++) begin
      if (i % 4 == 0) send_comma();
      else send_data();
      if (i == 27) chk({name, "_prelock"}, rxIsAligned, 0);
    end
    chk({name, "_lock"}, rxIsAligned, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int r;
  logic [15:0] d;
  logic [1:0] k;
  logic [1:0] nit;
  logic [1:0] de;
  int nslide;
  int nerr;
  int last;
  bit gap_ok;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_slide", rxSlide, 0);
    chk("rst_aligned", rxIsAligned, 0);
    chk("rst_evValid", evValid, 0);
    chk("rst_evCode", evCode, 0);
    chk("rst_dbus", dbusData, 0);
    chk("rst_cerr", codeErrCount, 0);
    #1 rst_n = 1'b1;

    // Clean comma every 4th word: lock after 8th, no slides.
    nslide = 0;
    for (int i = 0; i <= 28; i++) begin
      if (i % 4 == 0) send_comma();
      else send_data();
      nslide += int'(rxSlide);
      if (i == 27) chk("p1_prelock", rxIsAligned, 0);
    end
    chk("p1_lock", rxIsAligned, 1);
    chk("p1_no_slide", nslide, 0);

    // Event and dbus decode.
    send(16'h5A7E, 2'b00, 2'b00, 2'b00);
    chk("ev_code", evCode, 8'h7E);
    chk("ev_valid", evValid, 1);
    chk("ev_dbus", dbusData, 8'h5A);
    send(16'h3300, 2'b00, 2'b00, 2'b00);
    chk("null_ev_valid", evValid, 0);
    chk("null_ev_code", evCode, 8'h7E);
    chk("null_dbus", dbusData, 8'h33);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      d = {8'($urandom()), 8'($urandom())};
      k = 2'b00;
      nit = 2'b00;
      de = 2'b00;
      slideRequest = (r < 5);
      if (r >= 5 && r < 13) begin
        nit = 2'($urandom_range(0, 3));
        de = 2'($urandom_range(1, 3));
      end else if (r >= 13 && r < 21) begin
        d[15:8] = COMMA;
        k = 2'b10;
      end else if (i % 4 == 0) begin
        d[7:0] = COMMA;
        k = 2'b01;
      end else begin
        if (r < 200) d[7:0] = 8'h00;
        k[1] = (r < 260);
        k[0] = (r >= 900);
      end
      send(d, k, nit, de);
    end
    slideRequest = 1'b0;

    // Four errors in one window force unlock.
    do_reset();
    do_lock("p4");
    for (int e = 0; e < 4; e++) begin
      send_err();
      if (e < 3) chk("err_still_locked", rxIsAligned, 1);
      else begin
        chk("err_unlock", rxIsAligned, 0);
        chk("err_cerr4", codeErrCount, 4);
        chk("err_no_ev", evValid, 0);
      end
      send_comma();
      send_data();
      send_data();
    end

    // Three errors per window keeps lock.
    do_reset();
    do_lock("p5");
    nerr = 0;
    for (int i = 0; i < 700; i++) begin
      if ((m_cyc % 256) inside {60, 120, 180}) begin
        send_err();
        nerr++;
      end else if (m_cyc % 4 == 0) send_comma();
      else send_data();
    end
    chk("win3_locked", rxIsAligned, 1);
    chk("win3_cerr", codeErrCount, nerr);

    // Comma timeout.
    do_reset();
    do_lock("p6");
    for (int i = 0; i < COMMA_TIMEOUT - 1; i++) send_data();
    chk("to_before", rxIsAligned, 1);
    send_data();
    chk("to_unlock", rxIsAligned, 0);

    // Manual slide request while locked.
    do_reset();
    do_lock("p7");
    slideRequest = 1'b1;
    send_data();
    chk("req_slide", rxSlide, 1);
    chk("req_unlock", rxIsAligned, 0);
    send_data();
    chk("req_single", rxSlide, 0);
    for (int i = 0; i < 40; i++) send_data();
    slideRequest = 1'b0;
    send_data();

    // High-byte commas: repeated slides, then low-byte lock.
    do_reset();
    nslide = 0;
    last = -1;
    gap_ok = 1;
    for (int i = 0; i < 300 && nslide < 3; i++) begin
      if (i % 4 == 0)
        send({COMMA, 8'($urandom_range(0, 127))},
             2'b10, 2'b00, 2'b00);
      else send_data();
      if (i == 0) chk("hi_first_slide", rxSlide, 1);
      if (rxSlide) begin
        if (last >= 0 && i - last < SLIDE_WAIT + 2)
          gap_ok = 0;
        last = i;
        nslide++;
      end
    end
    chk("hi_pulses", nslide, 3);
    chk("hi_gap", gap_ok, 1);
    nslide = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 4 == 0) send_comma();
      else send_data();
      nslide += int'(rxSlide);
    end
    chk("hi_relock", rxIsAligned, 1);
    chk("hi_no_more_slide", nslide, 0);

    // Reset mid-SLIDE.
    do_reset();
    send({COMMA, 8'h00}, 2'b10, 2'b00, 2'b00);
    chk("mid_slide_pulse", rxSlide, 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_slide_rst", rxSlide, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-WAIT with nonzero decode state.
    do_lock("p9");
    send(16'hA53C, 2'b00, 2'b00, 2'b00);
    send_err();
    chk("p9_code", evCode, 8'h3C);
    chk("p9_dbus", dbusData, 8'hA5);
    chk("p9_cerr", codeErrCount, 1);
    send({COMMA, 8'h00}, 2'b10, 2'b00, 2'b00);
    chk("p9_hi_unlock", rxIsAligned, 0);
    chk("p9_hi_noslide", rxSlide, 0);
    send({COMMA, 8'h00}, 2'b10, 2'b00, 2'b00);
    chk("p9_slide", rxSlide, 1);
    repeat (5) send_data();
    #2 rst_n = 1'b0;
    #1;
    chk("wrst_slide", rxSlide, 0);
    chk("wrst_aligned", rxIsAligned, 0);
    chk("wrst_evValid", evValid, 0);
    chk("wrst_evCode", evCode, 0);
    chk("wrst_dbus", dbusData, 0);
    chk("wrst_cerr", codeErrCount, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    send({COMMA, 8'h00}, 2'b10, 2'b00, 2'b00);
    chk("wrst_hunt", rxSlide, 1);
    repeat (3) send_data();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
